// File: rtl/adc78h90_scan.sv
// rtl/adc78h90_scan.sv - round-robin channel sequencer for the ADC78H90 SPI ADC
// Each frame sends the next channel address and returns the conversion of the previous one.
module adc78h90_scan #(
  parameter int CLK_DIV = 8,
  parameter int NCH     = 4,
  parameter int GAP_CYC = 16
) (
  input  logic        IF_clk,
  input  logic        IF_rst,
  input  logic        enable,
  output logic        nADCCS,
  output logic        ADCCLK,
  output logic        ADCMOSI,
  input  logic        ADCMISO,
  output logic [11:0] data,
  output logic [2:0]  data_ch,
  output logic        data_valid,
  output logic        frame_err
);
  typedef enum logic [2:0] {IDLE, SETUP, CLK_LO, CLK_HI, HOLD, GAP} state_t;

  localparam logic [9:0] DIV_LD  = 10'(CLK_DIV - 1);
  localparam logic [9:0] GAP_LD  = 10'(GAP_CYC - 1);
  localparam logic [2:0] LAST_CH = 3'(NCH - 1);

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shift_q;
  logic [2:0]  addr_q, prev_addr_q;
  logic        primed_q;
  logic        cs_n_q, sclk_q, mosi_q;
  logic [11:0] data_q;
  logic [2:0]  data_ch_q;
  logic        valid_q, err_q;
  logic        last_cyc, frame_done, sclk_fall, setup_entry;
  logic [15:0] ctrl_word;

  assign last_cyc    = (cnt_q == '0);
  assign ctrl_word   = {2'b00, addr_q, 11'b0};
  assign frame_done  = (state_q == HOLD) && last_cyc;
  assign sclk_fall   = (state_d == CLK_LO) && (state_q != CLK_LO);
  assign setup_entry = (state_d == SETUP) && (state_q != SETUP);

  always_ff @(posedge IF_clk) begin
    if (IF_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  // One down-counter times every state; a state ends when it reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = last_cyc ? cnt_q : cnt_q - 10'd1;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: if (enable) begin
        state_d = SETUP;
        cnt_d   = DIV_LD;
        bit_d   = '0;
      end
      SETUP: if (last_cyc) begin
        state_d = CLK_LO;
        cnt_d   = DIV_LD;
      end
      CLK_LO: if (last_cyc) begin
        state_d = CLK_HI;
        cnt_d   = DIV_LD;
      end
      CLK_HI: if (last_cyc) begin
        cnt_d = DIV_LD;
        if (bit_q == 4'd15) begin
          state_d = HOLD;
        end else begin
          state_d = CLK_LO;
          bit_d   = bit_q + 4'd1;
        end
      end
      HOLD: if (last_cyc) begin
        state_d = GAP;
        cnt_d   = GAP_LD;
      end
      GAP: if (last_cyc) begin
        if (enable) begin
          state_d = SETUP;
          cnt_d   = DIV_LD;
          bit_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin levels are registered from the next state so they line up with state_q.
  always_ff @(posedge IF_clk) begin
    if (IF_rst) begin
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      mosi_q      <= 1'b0;
      shift_q     <= '0;
      addr_q      <= '0;
      prev_addr_q <= '0;
      primed_q    <= 1'b0;
      data_q      <= '0;
      data_ch_q   <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cs_n_q  <= (state_d == IDLE) || (state_d == GAP);
      sclk_q  <= (state_d != CLK_LO);
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (setup_entry) begin
        mosi_q <= ctrl_word[15];
      end else if (sclk_fall) begin
        mosi_q <= ctrl_word[~bit_d];
      end
      if ((state_q == CLK_HI) && last_cyc) begin
        shift_q <= {shift_q[14:0], ADCMISO};
      end
      if (state_q == IDLE) begin
        primed_q <= 1'b0;
      end
      if (frame_done) begin
        addr_q      <= (addr_q == LAST_CH) ? 3'd0 : addr_q + 3'd1;
        prev_addr_q <= addr_q;
        primed_q    <= 1'b1;
        if (primed_q) begin
          data_q    <= shift_q[11:0];
          data_ch_q <= prev_addr_q;
          valid_q   <= 1'b1;
          err_q     <= |shift_q[15:12];
        end
      end
    end
  end

  assign nADCCS     = cs_n_q;
  assign ADCCLK     = sclk_q;
  assign ADCMOSI    = mosi_q;
  assign data       = data_q;
  assign data_ch    = data_ch_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
endmodule

// File: tb/tb_adc78h90_scan.sv
// tb/tb_adc78h90_scan.sv - directed bench for adc78h90_scan with a behavioural ADC78H90
module tb_adc78h90_scan;
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, miso = 1'b0;
  logic        ncs, sclk, mosi, dv, ferr;
  logic [11:0] data;
  logic [2:0]  data_ch;
  int          checks = 0, errors = 0, cyc = 0;

  adc78h90_scan #(.CLK_DIV(2), .NCH(4), .GAP_CYC(4)) dut (
    .IF_clk(clk), .IF_rst(rst), .enable(enable), .nADCCS(ncs), .ADCCLK(sclk),
    .ADCMOSI(mosi), .ADCMISO(miso), .data(data), .data_ch(data_ch),
    .data_valid(dv), .frame_err(ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model state
  logic        prev_cs = 1'b1, prev_sclk = 1'b1, err_mode = 1'b0, prev_dv = 1'b0;
  logic [15:0] rx = '0, mword = '0;
  logic [2:0]  model_ch = '0;
  int          rises = 0, falls = 0, run_len = 0, bad_phase = 0, wide = 0;
  int          fall_q[$], rise_q[$], st_cyc[$];
  logic [2:0]  addr_q[$];
  logic [15:0] st_q[$];

  function automatic logic [15:0] adc_word(input logic [2:0] ch, input logic em);
    case (ch)
      3'd0:    return 16'h0ABC;
      3'd1:    return em ? 16'h4555 : 16'h0123;
      3'd2:    return 16'h0FFF;
      default: return 16'h0000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (ncs === 1'b0 && prev_cs === 1'b1) begin
      rises = 0; falls = 0; rx = '0;
      mword = adc_word(model_ch, err_mode);
      fall_q.push_back(cyc);
    end
    if (ncs === 1'b0 && sclk !== prev_sclk) begin
      if (run_len != 2 && (prev_sclk === 1'b0 || rises > 0)) bad_phase++;
      if (sclk === 1'b0) begin
        if (falls < 16) miso = mword[15-falls];
        falls++;
      end else begin
        rx = {rx[14:0], mosi};
        rises++;
      end
    end
    if (sclk !== prev_sclk) run_len = 1; else run_len++;
    if (ncs === 1'b1 && prev_cs === 1'b0) begin
      rise_q.push_back(rises);
      addr_q.push_back(rx[13:11]);
      model_ch = rx[13:11];
    end
    prev_cs = ncs; prev_sclk = sclk;
  end

  always @(negedge clk) begin
    if (dv === 1'b1) begin
      st_q.push_back({ferr, data_ch, data});
      st_cyc.push_back(cyc);
      if (prev_dv) wide++;
    end
    prev_dv = (dv === 1'b1);
  end

  task automatic wait_frame(input int budget, input string name);
    int n;
    n = addr_q.size();
    for (int i = 0; i < budget && addr_q.size() == n; i++) @(negedge clk);
    checks++;
    if (addr_q.size() == n) begin errors++; $display("FAIL %s: no frame end within %0d cycles", name, budget); end
  endtask

  task automatic wait_mid(input int budget, input string name);
    for (int i = 0; i < budget && !(ncs === 1'b0 && rises == 7); i++) @(negedge clk);
    checks++;
    if (!(ncs === 1'b0 && rises == 7)) begin errors++; $display("FAIL %s: bit 7 not reached, rises=%0d", name, rises); end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (ncs !== 1'b1) begin errors++; $display("FAIL reset_ncs: got %b want 1", ncs); end
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b want 1", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    checks++; if (data !== 12'h000) begin errors++; $display("FAIL reset_data: got %h want 000", data); end
    checks++; if (data_ch !== 3'd0) begin errors++; $display("FAIL reset_ch: got %0d want 0", data_ch); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", ferr); end
    checks++; if (st_q.size() != 0) begin errors++; $display("FAIL reset_strobes: got %0d want 0", st_q.size()); end
  endtask

  task automatic test_frame_format;
    logic [2:0] exp_addr [6];
    exp_addr = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
    enable = 1'b1;
    for (int i = 0; i < 800 && addr_q.size() < 6; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (addr_q.size() < 6) begin errors++; $display("FAIL frame_count: got %0d want 6", addr_q.size()); end
    for (int i = 0; i < 6 && i < addr_q.size(); i++) begin
      checks++; if (addr_q[i] !== exp_addr[i]) begin errors++; $display("FAIL frame_addr%0d: got %0d want %0d", i, addr_q[i], exp_addr[i]); end
      checks++; if (rise_q[i] != 16) begin errors++; $display("FAIL frame_rises%0d: got %0d want 16", i, rise_q[i]); end
    end
    for (int i = 0; i < 5 && i + 1 < fall_q.size(); i++) begin
      checks++; if (fall_q[i+1] - fall_q[i] != 72) begin errors++; $display("FAIL frame_period%0d: got %0d want 72", i, fall_q[i+1] - fall_q[i]); end
    end
    checks++; if (bad_phase != 0) begin errors++; $display("FAIL sclk_phase: got %0d bad phases want 0", bad_phase); end
  endtask

  task automatic test_data_path;
    logic [15:0] exp_st [5];
    exp_st = '{{1'b0, 3'd0, 12'hABC}, {1'b0, 3'd1, 12'h123}, {1'b0, 3'd2, 12'hFFF},
               {1'b0, 3'd3, 12'h000}, {1'b0, 3'd0, 12'hABC}};
    checks++; if (st_q.size() != 5) begin errors++; $display("FAIL strobe_count: got %0d want 5", st_q.size()); end
    for (int i = 0; i < 5 && i < st_q.size(); i++) begin
      checks++; if (st_q[i] !== exp_st[i]) begin errors++; $display("FAIL strobe%0d: got %h want %h", i, st_q[i], exp_st[i]); end
    end
    if (st_cyc.size() > 0 && fall_q.size() > 1) begin
      checks++; if (st_cyc[0] - fall_q[1] != 68) begin errors++; $display("FAIL strobe_latency: got %0d want 68", st_cyc[0] - fall_q[1]); end
    end
  endtask

  task automatic test_error_flag;
    logic [15:0] w, exp;
    logic [2:0]  ch;
    int          seen1;
    seen1 = 0;
    wait_frame(200, "err_sync");
    @(negedge clk); err_mode = 1'b1; st_q.delete();
    for (int i = 0; i < 400 && st_q.size() < 4; i++) @(negedge clk);
    checks++; if (st_q.size() < 4) begin errors++; $display("FAIL err_count: got %0d want 4", st_q.size()); end
    for (int i = 0; i < 4 && i < st_q.size(); i++) begin
      ch = st_q[i][14:12];
      w = adc_word(ch, 1'b0);
      exp = (ch == 3'd1) ? {1'b1, 3'd1, 12'h555} : {1'b0, ch, w[11:0]};
      if (ch == 3'd1) seen1++;
      checks++; if (st_q[i] !== exp) begin errors++; $display("FAIL err_strobe%0d: got %h want %h", i, st_q[i], exp); end
      if (i > 0) begin
        checks++; if (ch !== 3'(st_q[i-1][14:12] + 3'd1) && !(ch == 3'd0 && st_q[i-1][14:12] == 3'd3)) begin
          errors++; $display("FAIL err_seq%0d: got ch %0d after %0d", i, ch, st_q[i-1][14:12]);
        end
      end
    end
    checks++; if (seen1 != 1) begin errors++; $display("FAIL err_ch1_seen: got %0d want 1", seen1); end
    err_mode = 1'b0;
    wait_frame(200, "err_flush1");
    wait_frame(200, "err_flush2");
  endtask

  task automatic test_enable_drop;
    logic [2:0]  a, pa, na;
    logic [15:0] w, got;
    int          n;
    wait_mid(200, "drop_mid");
    enable = 1'b0; st_q.delete();
    wait_frame(200, "drop_frame");
    a = addr_q[$]; pa = a - 3'd1; pa[2] = 1'b0; na = a + 3'd1; na[2] = 1'b0;
    repeat (3) @(negedge clk);
    w = adc_word(pa, 1'b0);
    got = (st_q.size() > 0) ? st_q[0] : 16'hDEAD;
    checks++; if (st_q.size() != 1) begin errors++; $display("FAIL drop_strobe_count: got %0d want 1", st_q.size()); end
    checks++; if (got !== {1'b0, pa, w[11:0]}) begin errors++; $display("FAIL drop_strobe: got %h want %h", got, {1'b0, pa, w[11:0]}); end
    st_q.delete(); n = addr_q.size();
    repeat (60) @(negedge clk);
    checks++; if (addr_q.size() != n) begin errors++; $display("FAIL idle_frames: got %0d want %0d", addr_q.size(), n); end
    checks++; if (ncs !== 1'b1) begin errors++; $display("FAIL idle_ncs: got %b want 1", ncs); end
    checks++; if (st_q.size() != 0) begin errors++; $display("FAIL idle_strobes: got %0d want 0", st_q.size()); end
    enable = 1'b1;
    wait_frame(200, "reen_prime");
    repeat (2) @(negedge clk);
    checks++; if (st_q.size() != 0) begin errors++; $display("FAIL reen_prime_strobe: got %0d want 0", st_q.size()); end
    checks++; if (addr_q[$] !== na) begin errors++; $display("FAIL reen_addr: got %0d want %0d", addr_q[$], na); end
    wait_frame(200, "reen_second");
    repeat (2) @(negedge clk);
    w = adc_word(na, 1'b0);
    got = (st_q.size() > 0) ? st_q[0] : 16'hDEAD;
    checks++; if (st_q.size() != 1) begin errors++; $display("FAIL reen_strobe_count: got %0d want 1", st_q.size()); end
    checks++; if (got !== {1'b0, na, w[11:0]}) begin errors++; $display("FAIL reen_strobe: got %h want %h", got, {1'b0, na, w[11:0]}); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] got;
    wait_mid(200, "rst_mid");
    rst = 1'b1; st_q.delete();
    @(posedge clk); #1;
    checks++; if (ncs !== 1'b1) begin errors++; $display("FAIL rstmid_ncs: got %b want 1", ncs); end
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL rstmid_sclk: got %b want 1", sclk); end
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", dv); end
    repeat (2) @(negedge clk);
    rst = 1'b0; addr_q.delete(); rise_q.delete();
    checks++; if (st_q.size() != 0) begin errors++; $display("FAIL rstmid_strobe: got %0d want 0", st_q.size()); end
    wait_frame(200, "rstmid_prime");
    repeat (2) @(negedge clk);
    checks++; if (addr_q.size() < 1 || addr_q[0] !== 3'd0) begin errors++; $display("FAIL rstmid_addr0: got %0d want 0", addr_q.size() > 0 ? addr_q[0] : 3'd7); end
    checks++; if (rise_q.size() < 1 || rise_q[0] != 16) begin errors++; $display("FAIL rstmid_rises: got %0d want 16", rise_q.size() > 0 ? rise_q[0] : -1); end
    checks++; if (st_q.size() != 0) begin errors++; $display("FAIL rstmid_prime_strobe: got %0d want 0", st_q.size()); end
    wait_frame(200, "rstmid_second");
    repeat (2) @(negedge clk);
    got = (st_q.size() > 0) ? st_q[0] : 16'hDEAD;
    checks++; if (st_q.size() != 1) begin errors++; $display("FAIL rstmid_strobe_count: got %0d want 1", st_q.size()); end
    checks++; if (got !== 16'h0ABC) begin errors++; $display("FAIL rstmid_first: got %h want 0abc", got); end
    checks++; if (addr_q.size() < 2 || addr_q[1] !== 3'd1) begin errors++; $display("FAIL rstmid_addr1: got %0d want 1", addr_q.size() > 1 ? addr_q[1] : 3'd7); end
  endtask

  initial begin
    test_reset();
    test_frame_format();
    test_data_path();
    test_error_flag();
    test_enable_drop();
    test_reset_mid();
    checks++; if (wide != 0) begin errors++; $display("FAIL strobe_width: got %0d wide strobes want 0", wide); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/adc78h90_scan.md
# adc78h90_scan

Round-robin sequencer for the board's ADC78H90 8-channel 12-bit SPI ADC (forward/reverse power, supply and temperature sense). It sits between the top-level ADC pins (nADCCS, ADCCLK, ADCMOSI, ADCMISO) and the Hermes-Lite core's telemetry logic. It continuously scans channels 0..NCH-1 and emits one tagged 12-bit result per SPI frame as a single-cycle valid strobe.

## Interface
Parameters:
- CLK_DIV, default 8: SCLK half-period in IF_clk cycles; legal range 2..255.
- NCH, default 4: number of channels scanned, starting at channel 0; legal range 1..8.
- GAP_CYC, default 16: IF_clk cycles nADCCS stays high between frames; legal range 1..1023.

Ports:
- IF_clk  in  1  system clock; all logic is in this domain. One clock only; reset is synchronous and active-high.
- IF_rst  in  1  synchronous active-high reset.
- enable  in  1  when high, frames run back-to-back; when low, the current frame completes and the block then parks in IDLE.
- nADCCS  out  1  ADC chip select, active low.
- ADCCLK  out  1  SCLK; idles high.
- ADCMOSI  out  1  control bits to ADC DIN.
- ADCMISO  in  1  ADC DOUT; the board synchronizes it externally.
- data  out  12  last conversion result.
- data_ch  out  3  channel number that data belongs to.
- data_valid  out  1  one-cycle strobe; data and data_ch are valid while it is high.
- frame_err  out  1  one-cycle strobe coincident with data_valid when any of the 4 leading DOUT bits was 1.

## Operation
- Reset values: nADCCS=1, ADCCLK=1, ADCMOSI=0, data=0, data_ch=0, data_valid=0, frame_err=0. The state machine returns to IDLE, the address counter to 0, and the prime flag is cleared. Reset in mid-frame aborts the frame immediately and produces no strobe.
- FSM states: IDLE, SETUP, CLK_LO, CLK_HI, HOLD, GAP. A single divider counter times every state.
- IDLE: nADCCS=1, ADCCLK=1. When enable=1, go to SETUP.
- SETUP (CLK_DIV cycles): nADCCS=0, ADCCLK=1, ADCMOSI=control bit 15.
- CLK_LO / CLK_HI: 16 pairs, each phase lasting CLK_DIV cycles. On entry to each CLK_LO, ADCCLK=0 and ADCMOSI=control bit [15-k], where k = pair index 0..15. On entry to CLK_HI, ADCCLK=1.
- ADCMISO is shifted into a 16-bit register on the last IF_clk cycle of each CLK_HI phase, MSB first.
- After the 16th CLK_HI, go to HOLD (CLK_DIV cycles): ADCCLK=1, nADCCS=0.
- GAP (GAP_CYC cycles): nADCCS=1. At the end of GAP, go to SETUP if enable=1, otherwise to IDLE.
- Control word: {2'b00, addr[2:0], 11'b0}, with the address bits on frame bits 13:11.
- Pipeline: the ADC returns the conversion for the address sent in the previous frame. The block keeps prev_addr.
- The first frame after reset or after leaving IDLE only primes the pipeline and produces no strobe. In every later frame, on the first GAP cycle: data=shift[11:0], data_ch=prev_addr, data_valid=1, frame_err=|shift[15:12].
- Address sequencing: addr increments once per frame, after SETUP-to-HOLD completes. It wraps from NCH-1 to 0; with NCH=1 it stays 0.
- prev_addr takes the old addr when addr advances.
- enable is sampled only in IDLE and at the end of GAP. Deasserting it mid-frame has no effect on that frame.
- data and data_ch hold their values between strobes.

## Timing
- Frame period with enable held high: 34·CLK_DIV + GAP_CYC cycles. For CLK_DIV=2, GAP_CYC=4 this is 72 cycles.
- The ADCCLK frequency is IF_clk/(2·CLK_DIV). The integrator picks CLK_DIV to keep SCLK within the 0.5–8 MHz ADC limit.
- ADCMOSI changes only on the cycle ADCCLK falls, or on SETUP entry.
- nADCCS changes only while ADCCLK=1.
- data_valid latency: the strobe asserts exactly 1 cycle after the last HOLD cycle, which is 34·CLK_DIV cycles after the nADCCS falling edge.
- The strobe is never wider than 1 cycle. No strobe is issued during the prime frame.
- All outputs are registered, with no combinational path from ADCMISO or enable.

## Test plan
- Reset/idle: assert IF_rst for 3 cycles with enable=0, hold 100 cycles -> nADCCS=1, ADCCLK=1, ADCMOSI=0, data_valid never asserts.
- Frame format: CLK_DIV=2, GAP_CYC=4, NCH=4, enable=1, with an ADC model that checks for exactly 16 rising edges per CS-low window. The decoded address sequence must be 0,1,2,3,0,1. Check the frame period is 72 cycles and SCLK low/high phases are 2 cycles each.
- Data path: the model returns 0x0ABC for ch0, 0x0123 for ch1, 0x0FFF for ch2, and 0x0000 for ch3. The strobes must be (ch0,0xABC), (ch1,0x123), (ch2,0xFFF), (ch3,0x000), and the first frame must give no strobe. frame_err must stay 0 throughout.
- Error flag: the model drives leading bits 4'b0100 with value 0x555 on ch1 -> strobe with data=0x555, data_ch=1, frame_err=1.
- Enable drop: deassert enable mid-frame -> that frame completes, and its strobe fires if the block is already primed. The block then parks in IDLE. On re-enable, the next frame is a prime frame with no strobe, and strobes resume after that.
- Reset mid-frame: assert IF_rst at bit 7 -> the next cycle has nADCCS=1, ADCCLK=1, and there is no strobe. After reset releases, the scan restarts at channel 0 with a prime frame.
